// File: rtl/pwm_pkg.sv
// Shared constants for the PWM sequencer: FSM state encoding, entry-table
// depth and the width of the per-entry repeat count.
package pwm_pkg;

    localparam int unsigned TABLE_DEPTH = 4;
    localparam int unsigned IDX_BITS    = 2;
    localparam int unsigned REPEAT_BITS = 4;
    localparam int unsigned STATE_BITS  = 2;

    localparam logic [STATE_BITS-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_BITS-1:0] ST_LOAD = 2'd1;
    localparam logic [STATE_BITS-1:0] ST_RUN  = 2'd2;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: counts 0..final_value while enabled and raises tick in the
// clock where the count equals final_value, then wraps to 0.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   enable       - count while high
//   clear        - synchronous clear of the count
//   final_value  - last count value (tick period = final_value+1 clocks)
//   tick         - combinational, high in the last clock of each prescale period
module pwm_prescaler #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIDTH-1:0] final_value,
    output logic             tick
);

    logic [WIDTH-1:0] count;

    assign tick = enable && (count == final_value);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pwm_sequencer.sv
// PWM sequencer: plays up to four {duty, repeat} table entries in order, each
// for (repeat+1) PWM periods, optionally looping over the sequence.
// Ports:
//   clk, reset               - clock, synchronous active-high reset
//   start, stop              - level commands (stop has priority)
//   prescale                 - tick every prescale+1 clocks, latched on start
//   loop                     - repeat sequence, sampled at last-entry end
//   num_entries              - index of last entry, latched on start
//   wr_en/wr_addr/wr_duty/wr_repeat - entry-table write port
//   pwm_out                  - registered PWM waveform
//   busy, seg_idx, seq_done  - status: active, current entry, completion pulse
module pwm_sequencer
    import pwm_pkg::*;
#(
    parameter int unsigned TIMER_BITS = 4,
    parameter int unsigned PWM_BITS   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic [TIMER_BITS-1:0]  prescale,
    input  logic                   loop,
    input  logic [IDX_BITS-1:0]    num_entries,
    input  logic                   wr_en,
    input  logic [IDX_BITS-1:0]    wr_addr,
    input  logic [PWM_BITS-1:0]    wr_duty,
    input  logic [REPEAT_BITS-1:0] wr_repeat,
    output logic                   pwm_out,
    output logic                   busy,
    output logic [IDX_BITS-1:0]    seg_idx,
    output logic                   seq_done
);

    localparam logic [PWM_BITS-1:0] PWM_MAX = {PWM_BITS{1'b1}};

    logic [STATE_BITS-1:0]  state;
    logic [STATE_BITS-1:0]  state_nx;
    logic [IDX_BITS-1:0]    seg_nx;
    logic                   done_nx;
    logic                   pwm_nx;

    logic [TIMER_BITS-1:0]  prescale_q;
    logic [IDX_BITS-1:0]    num_q;
    logic [PWM_BITS-1:0]    active_duty;
    logic [REPEAT_BITS-1:0] active_repeat;
    logic [PWM_BITS-1:0]    pwm_cnt;
    logic [REPEAT_BITS-1:0] rep_cnt;

    logic [PWM_BITS-1:0]    duty_tbl [TABLE_DEPTH];
    logic [REPEAT_BITS-1:0] rep_tbl  [TABLE_DEPTH];

    logic tick;
    logic accept_c;
    logic period_end_c;
    logic seg_end_c;

    pwm_prescaler #(
        .WIDTH(TIMER_BITS)
    ) u_prescaler (
        .clk        (clk),
        .reset      (reset),
        .enable     (state == ST_RUN),
        .clear      (state == ST_LOAD),
        .final_value(prescale_q),
        .tick       (tick)
    );

    assign accept_c     = (state == ST_IDLE) && start && !stop;
    assign period_end_c = (state == ST_RUN) && tick && (pwm_cnt == PWM_MAX);
    assign seg_end_c    = period_end_c && (rep_cnt == active_repeat);

    // Next-state, next entry index and next registered outputs
    always_comb begin
        state_nx = state;
        seg_nx   = seg_idx;
        done_nx  = 1'b0;
        pwm_nx   = (state == ST_RUN) && (pwm_cnt < active_duty);
        case (state)
            ST_IDLE: begin
                if (accept_c) begin
                    state_nx = ST_LOAD;
                    seg_nx   = '0;
                end
            end
            ST_LOAD: begin
                state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (seg_end_c) begin
                    if (seg_idx < num_q) begin
                        seg_nx   = seg_idx + IDX_BITS'(1);
                        state_nx = ST_LOAD;
                    end else if (loop) begin
                        seg_nx   = '0;
                        state_nx = ST_LOAD;
                    end else begin
                        state_nx = ST_IDLE;
                        done_nx  = 1'b1;
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
        // Abort wins over every transition and silences the output at once
        if (stop) begin
            state_nx = ST_IDLE;
            seg_nx   = seg_idx;
            done_nx  = 1'b0;
            pwm_nx   = 1'b0;
        end
    end

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            seg_idx  <= '0;
            seq_done <= 1'b0;
            pwm_out  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nx;
            seg_idx  <= seg_nx;
            seq_done <= done_nx;
            pwm_out  <= pwm_nx;
            busy     <= (state_nx != ST_IDLE);
        end
    end

    // Datapath: latched command fields, active entry copy and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            prescale_q    <= '0;
            num_q         <= '0;
            active_duty   <= '0;
            active_repeat <= '0;
            pwm_cnt       <= '0;
            rep_cnt       <= '0;
        end else begin
            if (accept_c) begin
                prescale_q <= prescale;
                num_q      <= num_entries;
            end
            if (state == ST_LOAD) begin
                // Snapshot so later table writes cannot disturb this segment
                active_duty   <= duty_tbl[seg_idx];
                active_repeat <= rep_tbl[seg_idx];
                pwm_cnt       <= '0;
                rep_cnt       <= '0;
            end else if ((state == ST_RUN) && tick) begin
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
                if (period_end_c && !seg_end_c) begin
                    rep_cnt <= rep_cnt + REPEAT_BITS'(1);
                end
            end
        end
    end

    // Entry table, writable in any state
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TABLE_DEPTH; i++) begin
                duty_tbl[i] <= '0;
                rep_tbl[i]  <= '0;
            end
        end else if (wr_en) begin
            duty_tbl[wr_addr] <= wr_duty;
            rep_tbl[wr_addr]  <= wr_repeat;
        end
    end

endmodule

// File: tb/tb_pwm_sequencer.sv
// Testbench for pwm_sequencer (PWM_BITS=4, TIMER_BITS=4): directed scenarios
// with literal expectations plus randomized commands, all checked every cycle
// against a timeline model (segment offset arithmetic).
module tb_pwm_sequencer;

    localparam int PER = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loop = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] prescale = '0;
    logic [1:0] num_entries = '0;
    logic [1:0] wr_addr = '0;
    logic [3:0] wr_duty = '0;
    logic [3:0] wr_repeat = '0;
    logic       pwm_out;
    logic       busy;
    logic [1:0] seg_idx;
    logic       seq_done;

    always #5 clk = ~clk;

    pwm_sequencer #(
        .TIMER_BITS(4),
        .PWM_BITS  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .prescale   (prescale),
        .loop       (loop),
        .num_entries(num_entries),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_duty    (wr_duty),
        .wr_repeat  (wr_repeat),
        .pwm_out    (pwm_out),
        .busy       (busy),
        .seg_idx    (seg_idx),
        .seq_done   (seq_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- timeline model ----------------
    // Each active entry occupies offsets 0 (load clock) .. seg_len-1 (run clocks);
    // the PWM count at run offset o is ((o-1)/(prescale+1)) mod 16.
    int  m_tbl_duty [4];
    int  m_tbl_rep  [4];
    bit  m_active = 0;
    int  m_seg = 0, m_off = 0, m_ps = 0, m_num = 0, m_duty = 0, m_rep = 0, m_len = 0;
    bit  e_pwm = 0, e_done = 0;
    bit  chk_en = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_active = 0; m_seg = 0; m_off = 0; m_ps = 0; m_num = 0;
            m_duty = 0; m_rep = 0; e_pwm = 0; e_done = 0;
            for (int i = 0; i < 4; i++) begin
                m_tbl_duty[i] = 0;
                m_tbl_rep[i]  = 0;
            end
            chk_en = 1;
        end else begin
            e_done = 0;
            if (m_active && m_off == 0) begin
                m_duty = m_tbl_duty[m_seg];
                m_rep  = m_tbl_rep[m_seg];
            end
            if (stop) begin
                m_active = 0;
                e_pwm    = 0;
            end else if (!m_active) begin
                e_pwm = 0;
                if (start) begin
                    m_active = 1; m_seg = 0; m_off = 0;
                    m_ps = int'(prescale); m_num = int'(num_entries);
                end
            end else begin
                m_len = 1 + (m_rep + 1) * PER * (m_ps + 1);
                e_pwm = (m_off >= 1) && ((((m_off - 1) / (m_ps + 1)) % PER) < m_duty);
                m_off++;
                if (m_off == m_len) begin
                    m_off = 0;
                    if (m_seg < m_num) m_seg++;
                    else if (loop) m_seg = 0;
                    else begin
                        m_active = 0;
                        e_done   = 1;
                    end
                end
            end
            if (wr_en) begin
                m_tbl_duty[wr_addr] = int'(wr_duty);
                m_tbl_rep[wr_addr]  = int'(wr_repeat);
            end
        end
    end

    // Per-cycle compare plus simple statistics for literal expectations
    int st_high = 0, st_busy = 0, st_done = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("pwm_out",  32'(pwm_out),  32'(e_pwm));
            check("busy",     32'(busy),     32'(m_active));
            check("seg_idx",  32'(seg_idx),  32'(m_seg));
            check("seq_done", 32'(seq_done), 32'(e_done));
            if (pwm_out === 1'b1) st_high++;
            if (busy === 1'b1) st_busy++;
            if (seq_done === 1'b1) st_done++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_stats();
        st_high = 0; st_busy = 0; st_done = 0;
    endtask

    task automatic set_entry(input int a, input int d, input int r);
        wr_en = 1'b1; wr_addr = 2'(a); wr_duty = 4'(d); wr_repeat = 4'(r);
        cyc(1);
        wr_en = 1'b0;
    endtask

    task automatic do_start(input int ps, input int num, input bit lp);
        prescale = 4'(ps); num_entries = 2'(num); loop = lp;
        start = 1'b1;
        clr_stats();
        cyc(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < max_cyc) begin
            cyc(1);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle timeout after %0d cycles: busy=%0d, expected 0", n, busy);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_pwm", 32'(pwm_out), 32'd0);
        cyc(2);

        // Single entry {4,0}, prescale 0
        set_entry(0, 4, 0);
        do_start(0, 0, 1'b0);
        wait_idle(100);
        cyc(2);
        check("single_high", 32'(st_high), 32'd4);
        check("single_busy", 32'(st_busy), 32'd17);
        check("single_done", 32'(st_done), 32'd1);

        // Three-entry sequence, prescale 1
        set_entry(0, 0, 1);
        set_entry(1, 15, 0);
        set_entry(2, 8, 2);
        do_start(1, 2, 1'b0);
        wait_idle(400);
        cyc(2);
        check("seq_high", 32'(st_high), 32'd78);
        check("seq_busy", 32'(st_busy), 32'd195);
        check("seq_done", 32'(st_done), 32'd1);

        // Looping: two full passes, then stop mid-period
        do_start(1, 2, 1'b1);
        cyc(2 * 195 + 40);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        check("loop_no_done", 32'(st_done), 32'd0);
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_pwm", 32'(pwm_out), 32'd0);
        cyc(2);

        // start and stop together in IDLE
        start = 1'b1; stop = 1'b1;
        cyc(1);
        start = 1'b0; stop = 1'b0;
        check("startstop_busy", 32'(busy), 32'd0);
        cyc(2);

        // start pulse while running is ignored
        do_start(1, 2, 1'b0);
        cyc(80);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("restart_seg", 32'(seg_idx), 32'd1);
        wait_idle(400);
        cyc(2);

        // Table write to the active entry during a looping run
        set_entry(0, 4, 0);
        do_start(0, 0, 1'b1);
        cyc(4);
        set_entry(0, 12, 0);
        cyc(28);
        check("tblwr_high", 32'(st_high), 32'd16);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        cyc(2);

        // Reset during run, then start with a cleared table
        set_entry(1, 9, 1);
        do_start(0, 1, 1'b1);
        cyc(25);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pwm", 32'(pwm_out), 32'd0);
        check("rst_seg", 32'(seg_idx), 32'd0);
        check("rst_done", 32'(seq_done), 32'd0);
        do_start(0, 0, 1'b0);
        wait_idle(100);
        cyc(2);
        check("clean_high", 32'(st_high), 32'd0);
        check("clean_busy", 32'(st_busy), 32'd17);
        check("clean_done", 32'(st_done), 32'd1);

        // Randomized commands and table writes
        for (int i = 0; i < 4000; i++) begin
            reset       = ($urandom_range(0, 299) == 0);
            stop        = ($urandom_range(0, 79) == 0);
            start       = ($urandom_range(0, 7) == 0);
            loop        = ($urandom_range(0, 3) == 0);
            prescale    = 4'($urandom_range(0, 2));
            num_entries = 2'($urandom_range(0, 3));
            wr_en       = ($urandom_range(0, 9) == 0);
            wr_addr     = 2'($urandom_range(0, 3));
            wr_duty     = 4'($urandom_range(0, 15));
            wr_repeat   = 4'($urandom_range(0, 1));
            cyc(1);
        end
        reset = 1'b0; start = 1'b0; wr_en = 1'b0;
        stop = 1'b1;
        cyc(2);
        stop = 1'b0;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_sequencer.md
PWM_SEQUENCER -- requirements
Module: pwm_sequencer

Interface
REQ-001 SHALL have parameter TIMER_BITS, default 4, prescaler width.
REQ-002 SHALL have parameter PWM_BITS, default 8, PWM counter and duty width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  level, sampled every clock; when high in IDLE, begins the sequence at entry 0.
REQ-006 SHALL have port stop  input  1  level, sampled every clock; when high, aborts to IDLE.
REQ-007 SHALL have port prescale  input  TIMER_BITS  tick every prescale+1 clocks; latched when start is accepted.
REQ-008 SHALL have port loop  input  1  repeat sequence endlessly; sampled at last-entry completion.
REQ-009 SHALL have port num_entries  input  2  index of last entry (0..3); latched when start is accepted.
REQ-010 SHALL have ports wr_en  input  1, wr_addr  input  2, wr_duty  input  PWM_BITS, wr_repeat  input  4  entry-table write port.
REQ-011 SHALL have port pwm_out  output  1  registered PWM waveform.
REQ-012 SHALL have ports busy  output  1 (state != IDLE), seg_idx  output  2 (current entry), seq_done  output  1 (one-clock completion pulse).

Function
REQ-013 SHALL hold a 4-entry table {duty, repeat}; wr_en writes entry wr_addr at the clock edge, in any state.
REQ-014 SHALL implement FSM IDLE, LOAD, RUN.
- IDLE -> LOAD on start: latch prescale and num_entries; set seg_idx=0.
- LOAD (exactly one clock) -> RUN: copy table[seg_idx] into active_duty/active_repeat; clear prescaler, PWM counter and repeat counter.
REQ-015 In RUN, the prescaler SHALL count 0..prescale and raise tick in the clock where count==prescale, then wrap to 0.
REQ-016 On each tick, the PWM counter SHALL increment modulo 2^PWM_BITS; period = 2^PWM_BITS*(prescale+1) clocks.
REQ-017 On a tick with PWM counter == 2^PWM_BITS-1, one period SHALL end.
- repeat counter != active_repeat: increment it and stay in RUN.
- otherwise the segment ends.
REQ-018 Segment end:
- seg_idx < num_entries: seg_idx+1, go to LOAD.
- seg_idx == num_entries and loop=1: seg_idx=0, go to LOAD.
- seg_idx == num_entries and loop=0: go to IDLE; seq_done high for that one clock.
REQ-019 Each entry SHALL last (repeat+1) periods plus the one LOAD clock.
REQ-020 pwm_out SHALL be registered: next value = (state==RUN) && (PWM counter < active_duty).
- duty=0 gives constant low.
- duty=2^PWM_BITS-1 gives high for all counts except the last.
REQ-021 stop SHALL take priority over all transitions: go to IDLE next clock, pwm_out low, no seq_done; start and stop high together in IDLE leave the block in IDLE.
REQ-022 start SHALL be ignored while busy.
REQ-023 A table write to the active entry SHALL NOT alter the running segment; it takes effect at that entry's next LOAD.

Reset
REQ-024 reset SHALL, at the next clock edge, force state IDLE; pwm_out, seq_done, seg_idx, all counters, latched prescale/num_entries and all table entries to 0.
REQ-025 reset SHALL override start, stop and wr_en in the same cycle.

Structure
REQ-026 State encoding, table depth (4) and repeat width (4) SHALL be constants in shared package pwm_pkg.
REQ-027 The prescaler SHALL be a sub-module pwm_prescaler (inputs: enable, synchronous clear, final value; output: tick).
REQ-028 Implementation SHALL use a single clock domain and no latches.

Verification (PWM_BITS=4, TIMER_BITS=4)
REQ-029 Single entry: entry0={4,0}, num_entries=0, prescale=0, loop=0, start at cycle 0.
- Required: busy high cycles 1-17; pwm_out high cycles 3-6, low otherwise; seq_done high at cycle 18 only; busy low at cycle 18.
REQ-030 Sequence: entries {0,1},{15,0},{8,2}, prescale=1.
- Required: pwm_out low 64 clocks; then high 30 and low 2; then three periods of 16 high / 16 low.
- Required: seg_idx steps 0,1,2; exactly one seq_done.
REQ-031 Same sequence as REQ-030 with loop=1, run 2 passes.
- Required: seg_idx 2->0 with no seq_done.
- Then stop mid-period: pwm_out low and busy low the following clock.
REQ-032 Command conflicts.
- start+stop together in IDLE: busy stays 0.
- start pulse during RUN: no restart; seg_idx unchanged.
REQ-033 Table write during RUN: write entry0 duty=12 while entry0 (duty 4) runs with loop=1.
- Required: current pass shows 4-high; next pass shows 12-high.
REQ-034 Reset during RUN: all outputs 0 next clock; a subsequent start with an unwritten table gives pwm_out constant low and seq_done after 17 clocks.
